// File: rtl/uart_rx_decoder_pkg.sv
// Shared definitions for the UART receive path of the two-digit display link.
// Holds the ASCII constants of the <tens><ones><CR> message format, the state
// encodings of the bit-level and message-level FSMs, and small digit helpers.
// The transmitter side uses the same constants.
package uart_rx_decoder_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;
  localparam logic [7:0] ASCII_CR   = 8'h0D;

  // Bit-level receiver states
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } bit_state_t;

  // Position inside the <tens><ones><CR> message
  typedef enum logic [1:0] {
    IDX0,
    IDX1,
    IDX2
  } msg_state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
  endfunction

  function automatic logic [3:0] digit_val(input logic [7:0] b);
    logic [7:0] d;
    d = b - ASCII_ZERO;
    return d[3:0];
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: input synchroniser, baud counter and bit FSM.
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-low reset
//   rx_in       asynchronous serial line, idle high
//   byte_out    last good data byte
//   byte_valid  1-cycle pulse per frame with stop bit = 1
//   frame_err   1-cycle pulse when the stop bit is sampled 0
module uart_rx_byte
  import uart_rx_decoder_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   rxs;

  bit_state_t  state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shreg, shreg_n;
  logic [7:0]  byte_n;
  logic        byte_valid_n;
  logic        frame_err_n;

  // Synchroniser resets to idle-high so a reset never looks like a start edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rx_in};
    end
  end

  assign rxs = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      shreg      <= shreg_n;
      byte_out   <= byte_n;
      byte_valid <= byte_valid_n;
      frame_err  <= frame_err_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    bit_idx_n    = bit_idx;
    shreg_n      = shreg;
    byte_n       = byte_out;
    byte_valid_n = 1'b0;
    frame_err_n  = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_n     = '0;
        bit_idx_n = '0;
        if (!rxs) begin
          state_n = START;
        end
      end

      // Confirm the start bit at its mid-point; all later samples are a
      // whole bit period apart from here, so they land mid-bit too.
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_n   = '0;
          state_n = rxs ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n     = '0;
          shreg_n   = {rxs, shreg[7:1]};
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      // Returning to IDLE at the stop mid-point lets a following start edge
      // be caught without waiting for the end of the stop bit.
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (rxs) begin
            byte_n       = shreg;
            byte_valid_n = 1'b1;
            state_n      = IDLE;
          end else begin
            frame_err_n = 1'b1;
            state_n     = BREAK;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      // A held-low line reports one frame error, then waits for idle
      BREAK: begin
        cnt_n = '0;
        if (rxs) begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: rtl/uart_rx_decoder.sv
// Receive side of the two-digit UART display link. Deserialises 8N1 frames
// and checks each message against <tens ASCII><ones ASCII><CR>, presenting
// the decoded digits with a one-cycle valid strobe.
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-low reset
//   rx_in       asynchronous serial line, idle high
//   bcd0        ones digit 0..9, zero-extended to 7 bits
//   bcd1        tens digit 0..9, zero-extended to 7 bits
//   msg_valid   1-cycle pulse, bcd0/bcd1 updated in the same cycle
//   byte_out    last received data byte
//   byte_valid  1-cycle pulse per good frame
//   frame_err   1-cycle pulse when a stop bit is sampled 0
//   msg_err     1-cycle pulse when a byte is out of place in the message
module uart_rx_decoder
  import uart_rx_decoder_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [6:0] bcd0,
  output logic [6:0] bcd1,
  output logic       msg_valid,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       msg_err
);

  msg_state_t mstate, mstate_n;
  logic [3:0] tens, tens_n;
  logic [3:0] ones, ones_n;
  logic [6:0] bcd0_n, bcd1_n;
  logic       msg_valid_n;
  logic       msg_err_n;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .SYNC_STAGES  (SYNC_STAGES)
  ) u_rx_byte (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      mstate    <= IDX0;
      tens      <= '0;
      ones      <= '0;
      bcd0      <= '0;
      bcd1      <= '0;
      msg_valid <= 1'b0;
      msg_err   <= 1'b0;
    end else begin
      mstate    <= mstate_n;
      tens      <= tens_n;
      ones      <= ones_n;
      bcd0      <= bcd0_n;
      bcd1      <= bcd1_n;
      msg_valid <= msg_valid_n;
      msg_err   <= msg_err_n;
    end
  end

  always_comb begin
    mstate_n    = mstate;
    tens_n      = tens;
    ones_n      = ones;
    bcd0_n      = bcd0;
    bcd1_n      = bcd1;
    msg_valid_n = 1'b0;
    msg_err_n   = 1'b0;

    if (frame_err) begin
      // Broken frame: drop any partial message silently
      mstate_n = IDX0;
    end else if (byte_valid) begin
      unique case (mstate)
        IDX0: begin
          if (is_digit(byte_out)) begin
            tens_n   = digit_val(byte_out);
            mstate_n = IDX1;
          end else begin
            msg_err_n = 1'b1;
            mstate_n  = IDX0;
          end
        end

        IDX1: begin
          if (is_digit(byte_out)) begin
            ones_n   = digit_val(byte_out);
            mstate_n = IDX2;
          end else begin
            msg_err_n = 1'b1;
            mstate_n  = IDX0;
          end
        end

        IDX2: begin
          if (byte_out == ASCII_CR) begin
            bcd1_n      = {3'b000, tens};
            bcd0_n      = {3'b000, ones};
            msg_valid_n = 1'b1;
          end else begin
            msg_err_n = 1'b1;
          end
          mstate_n = IDX0;
        end

        default: begin
          mstate_n = IDX0;
        end
      endcase
    end
  end

endmodule
